// File: rtl/fsm_core.sv
// fsm_core: serial popcount engine with interrupt/acknowledge reporting.
// A non-zero word captured in IDLE is shifted out LSB-first, one bit per
// clock, while an accumulator counts the ones. The result is published on
// data_out with intr, and held until the host acknowledges. Dropping ena
// mid-count aborts into HALT, where stop is raised until acknowledged.
module fsm_core #(
    parameter int DATA_W = 23,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              ack,
    input  logic              ena,
    input  logic [DATA_W-1:0] data_in,
    output logic              intr,
    output logic              specreg,
    output logic              stop,
    output logic [DATA_W-1:0] data_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        REPORT  = 2'd2,
        HALT    = 2'd3
    } state_t;

    // Bit counter value on the edge that consumes the last (MSB) bit.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    state_t            state_reg, state_next;
    logic [DATA_W-1:0] shift_reg, shift_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [CNT_W-1:0]  acc_reg, acc_next;
    logic              intr_reg, intr_next;
    logic              spec_reg, spec_next;
    logic              stop_reg, stop_next;
    logic [DATA_W-1:0] dout_reg, dout_next;

    // Accumulator including the bit currently at the bottom of the shifter.
    logic [CNT_W-1:0]  acc_sum;
    logic              last_bit;
    logic              word_zero;

    assign acc_sum   = acc_reg + {{(CNT_W-1){1'b0}}, shift_reg[0]};
    assign last_bit  = (cnt_reg == LAST_CNT);
    assign word_zero = (data_in == '0);

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!arst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (ena) begin
                    state_next = word_zero ? REPORT : COMPUTE;
                end
            end
            COMPUTE: begin
                if (!ena) begin
                    state_next = HALT;
                end else if (last_bit) begin
                    state_next = REPORT;
                end
            end
            REPORT: begin
                if (ack) begin
                    state_next = IDLE;
                end
            end
            HALT: begin
                if (ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath and output next values; everything holds unless a rule fires.
    always_comb begin
        shift_next = shift_reg;
        cnt_next   = cnt_reg;
        acc_next   = acc_reg;
        intr_next  = intr_reg;
        spec_next  = spec_reg;
        stop_next  = stop_reg;
        dout_next  = dout_reg;
        case (state_reg)
            IDLE: begin
                if (ena) begin
                    if (word_zero) begin
                        // Zero word needs no counting: report immediately.
                        spec_next = 1'b1;
                        dout_next = '0;
                        intr_next = 1'b1;
                    end else begin
                        spec_next  = 1'b0;
                        shift_next = data_in;
                        cnt_next   = '0;
                        acc_next   = '0;
                    end
                end
            end
            COMPUTE: begin
                if (!ena) begin
                    // Abort: partial count is dropped, published result kept.
                    stop_next = 1'b1;
                end else begin
                    acc_next   = acc_sum;
                    shift_next = shift_reg >> 1;
                    cnt_next   = cnt_reg + CNT_W'(1);
                    if (last_bit) begin
                        dout_next = {{(DATA_W-CNT_W){1'b0}}, acc_sum};
                        intr_next = 1'b1;
                    end
                end
            end
            REPORT: begin
                if (ack) begin
                    intr_next = 1'b0;
                end
            end
            HALT: begin
                if (ack) begin
                    stop_next = 1'b0;
                end
            end
            default: begin
                shift_next = '0;
                cnt_next   = '0;
                acc_next   = '0;
                intr_next  = 1'b0;
                spec_next  = 1'b0;
                stop_next  = 1'b0;
                dout_next  = '0;
            end
        endcase
    end

    // Datapath and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!arst) begin
            shift_reg <= '0;
            cnt_reg   <= '0;
            acc_reg   <= '0;
            intr_reg  <= 1'b0;
            spec_reg  <= 1'b0;
            stop_reg  <= 1'b0;
            dout_reg  <= '0;
        end else begin
            shift_reg <= shift_next;
            cnt_reg   <= cnt_next;
            acc_reg   <= acc_next;
            intr_reg  <= intr_next;
            spec_reg  <= spec_next;
            stop_reg  <= stop_next;
            dout_reg  <= dout_next;
        end
    end

    assign intr     = intr_reg;
    assign specreg  = spec_reg;
    assign stop     = stop_reg;
    assign data_out = dout_reg;

endmodule

// File: tb/tb_fsm_core.sv
// tb_fsm_core: scoreboard bench for fsm_core. Stimulus pushes the expected
// event (result or abort, value, flag, cycle of appearance) computed with
// $countones; a negedge monitor pops and compares on each intr/stop rise.
module tb_fsm_core;

    localparam int DATA_W = 23;
    localparam int CNT_W  = 5;

    logic              clk = 1'b0;
    logic              arst = 1'b0;
    logic              ack = 1'b0;
    logic              ena = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              intr;
    logic              specreg;
    logic              stop;
    logic [DATA_W-1:0] data_out;

    fsm_core #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .arst    (arst),
        .ack     (ack),
        .ena     (ena),
        .data_in (data_in),
        .intr    (intr),
        .specreg (specreg),
        .stop    (stop),
        .data_out(data_out)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far.
    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit                is_abort;
        logic [DATA_W-1:0] dout;
        bit                spec;
        int                at;
    } exp_t;

    exp_t sb[$];

    // Reference model: last published result and zero-word flag.
    logic [DATA_W-1:0] m_dout = '0;
    bit                m_spec = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full computation followed by acknowledge after wait_n cycles
    // (or ack held high throughout when ack_hold is set).
    task automatic run_word(input logic [DATA_W-1:0] d, input bit ack_hold, input int wait_n);
        exp_t e;
        ena     = 1'b1;
        data_in = d;
        ack     = ack_hold;
        if (d == '0) begin
            m_spec = 1'b1;
            m_dout = '0;
            e.at   = cyc + 1;
        end else begin
            m_spec = 1'b0;
            m_dout = DATA_W'($countones(d));
            e.at   = cyc + 1 + DATA_W;
        end
        e.is_abort = 1'b0;
        e.dout     = m_dout;
        e.spec     = m_spec;
        sb.push_back(e);
        tick();
        data_in = DATA_W'($urandom);
        if (d != '0) repeat (DATA_W) tick();
        ena = 1'b0;
        if (!ack_hold) begin
            repeat (wait_n) tick();
            check("intr_held", {31'd0, intr}, 32'd1);
            ack = 1'b1;
        end
        tick();
        check("intr_cleared", {31'd0, intr}, 32'd0);
        ack = 1'b0;
    endtask

    // Start a non-zero word, keep ena for k compute edges, then drop it.
    task automatic run_abort(input logic [DATA_W-1:0] d, input int k, input int wait_n);
        exp_t e;
        ena        = 1'b1;
        data_in    = d;
        ack        = 1'b0;
        m_spec     = 1'b0;
        e.is_abort = 1'b1;
        e.dout     = m_dout;
        e.spec     = 1'b0;
        e.at       = cyc + k + 2;
        sb.push_back(e);
        tick();
        repeat (k) tick();
        ena = 1'b0;
        tick();
        repeat (wait_n) tick();
        check("stop_held", {31'd0, stop}, 32'd1);
        ack = 1'b1;
        tick();
        check("stop_cleared", {31'd0, stop}, 32'd0);
        ack = 1'b0;
    endtask

    // Start a word, then hit reset after k compute edges.
    task automatic run_reset_mid(input logic [DATA_W-1:0] d, input int k);
        ena     = 1'b1;
        data_in = d;
        ack     = 1'b0;
        tick();
        repeat (k) tick();
        arst = 1'b0;
        tick();
        check("rst_mid_intr", {31'd0, intr}, 32'd0);
        check("rst_mid_stop", {31'd0, stop}, 32'd0);
        check("rst_mid_spec", {31'd0, specreg}, 32'd0);
        check("rst_mid_dout", {9'd0, data_out}, 32'd0);
        arst   = 1'b1;
        ena    = 1'b0;
        m_dout = '0;
        m_spec = 1'b0;
    endtask

    // Monitor: pops an expectation on every rising intr or stop.
    logic prev_intr = 1'b0;
    logic prev_stop = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        check("intr_stop_exclusive", {31'd0, (intr === 1'b1) && (stop === 1'b1)}, 32'd0);
        if ((intr === 1'b1 && prev_intr !== 1'b1) || (stop === 1'b1 && prev_stop !== 1'b1)) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: got intr=%0b stop=%0b want none (cycle %0d)", intr, stop, cyc);
            end else begin
                e = sb.pop_front();
                check("event_stop", {31'd0, stop}, {31'd0, e.is_abort});
                check("event_intr", {31'd0, intr}, {31'd0, !e.is_abort});
                check("data_out", {9'd0, data_out}, {9'd0, e.dout});
                check("specreg", {31'd0, specreg}, {31'd0, e.spec});
                check("latency_cycle", cyc, e.at);
            end
        end else if (sb.size() > 0 && cyc > sb[0].at + 2) begin
            e = sb.pop_front();
            total++;
            bad++;
            $display("FAIL event_timeout: got no event want one at cycle %0d (now %0d)", e.at, cyc);
        end
        prev_intr = intr;
        prev_stop = stop;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish by time 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DATA_W-1:0] d;
        int r;
        // Reset held with a start request pending.
        arst    = 1'b0;
        ena     = 1'b1;
        data_in = 23'h7FFFFF;
        tick();
        tick();
        check("rst_intr", {31'd0, intr}, 32'd0);
        check("rst_stop", {31'd0, stop}, 32'd0);
        check("rst_spec", {31'd0, specreg}, 32'd0);
        check("rst_dout", {9'd0, data_out}, 32'd0);
        arst = 1'b1;
        ena  = 1'b0;
        tick();
        tick();
        check("idle_intr", {31'd0, intr}, 32'd0);
        check("idle_dout", {9'd0, data_out}, 32'd0);

        // Directed cases.
        run_word(23'd65535, 1'b0, 2);
        run_word(23'h7FFFFF, 1'b0, 0);
        run_word(23'h555555, 1'b0, 1);
        run_word(23'd0, 1'b1, 0);
        run_abort(23'd65535, 10, 1);
        run_word(23'h00F0F0, 1'b0, 1);
        run_reset_mid(23'd65535, 7);
        run_word(23'd1, 1'b0, 0);

        // Randomized mix.
        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 9);
            d = DATA_W'($urandom);
            if (r == 0) d = '0;
            if (r == 1) d = 23'h7FFFFF;
            if (r == 2 || r == 3) begin
                run_abort(d | 23'd1, $urandom_range(0, DATA_W - 1), $urandom_range(0, 2));
            end else if (r == 4) begin
                run_reset_mid(d | 23'd1, $urandom_range(0, DATA_W - 2));
            end else begin
                run_word(d, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
            end
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (5) tick();
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
